// File: rtl/pulse_queue_mc.sv
// pulse_queue_mc: multi-channel pulse queue and spacer.
// Each channel counts incoming single-cycle events and replays them as
// single-cycle output pulses separated by at least GAP idle cycles.
// With mode_drop=1, events that arrive while a channel is busy are ignored.
// Overflow flags are sticky and record events lost to a full queue.
module pulse_queue_mc #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    parameter int GAP      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic                mode_drop,
    input  logic                clr_ovf,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] busy,
    output logic                any_busy,
    output logic [CHANNELS-1:0] overflow
);

    // Gap counter needs to hold GAP; keep at least one bit so GAP=0 still builds.
    localparam int GW = (GAP == 0) ? 1 : $clog2(GAP + 1);
    localparam logic [GW-1:0]    GAP_V    = GW'(GAP);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] pend;
        logic [GW-1:0]    gap_cnt;
        logic             pulse_q;
        logic             ovf_q;
        logic             fire;
        logic             full;
        logic             accept;
        logic             ovf_set;

        // Per-channel decisions, all taken from pre-edge register values.
        always_comb begin
            fire    = (pend != '0) && (gap_cnt == '0);
            full    = (pend == PEND_MAX);
            accept  = pulse_in[c] && !(mode_drop && busy[c]) && !(full && !fire);
            ovf_set = pulse_in[c] && !mode_drop && full && !fire;
        end

        // Queue depth, spacing countdown, output pulse and sticky overflow.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend    <= '0;
                gap_cnt <= '0;
                pulse_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                pulse_q <= fire;
                // Accept and fire together leave the depth unchanged, so a full
                // queue that fires can still take one more event without wrapping.
                if (accept && !fire) begin
                    pend <= pend + 1'b1;
                end else if (fire && !accept) begin
                    pend <= pend - 1'b1;
                end
                if (fire) begin
                    gap_cnt <= GAP_V;
                end else if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                // A set condition beats a clear in the same cycle.
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end else if (clr_ovf) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign pulse_out[c] = pulse_q;
        assign overflow[c]  = ovf_q;
        assign busy[c]      = (pend != '0) || (gap_cnt != '0);
    end

    assign any_busy = |busy;

endmodule
